// File: rtl/motor_cmd_packetizer.sv
// motor_cmd_packetizer
// Latches NUM_MOTORS command words and streams them as one ASCII JSON line,
// e.g. {"m0":05,"m1":1F}\n, over a valid/ready byte interface toward uart_tx.
// Frames are started by an internal ms-based period timer or by a change of
// motor_cmd relative to the last frame sent.
// Build option: define MOTOR_PKT_CHECKSUM_EN to insert '*' and two uppercase
// hex digits (XOR of '{' through '}') between '}' and '\n'.
module motor_cmd_packetizer #(
    parameter int NUM_MOTORS  = 2,
    parameter int CMD_W       = 5,
    parameter int CLKS_PER_MS = 50000,
    parameter int PERIOD_MS   = 200
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        mode_on_change,
    input  logic [NUM_MOTORS*CMD_W-1:0] motor_cmd,
    output logic [7:0]                  uart_data,
    output logic                        uart_valid,
    input  logic                        uart_ready,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        overrun
);
    localparam int H         = (CMD_W + 3) / 4;     // hex digits per channel
    localparam int HW        = 4 * H;               // zero-padded channel width
    localparam int CHAN_LEN  = 6 + H;               // "mN": + digits + ','
    localparam int CLOSE_POS = NUM_MOTORS * CHAN_LEN;
`ifdef MOTOR_PKT_CHECKSUM_EN
    localparam int LAST_POS  = CLOSE_POS + 4;
`else
    localparam int LAST_POS  = CLOSE_POS + 1;
`endif
    localparam int IDX_W = $clog2(LAST_POS + 1);
    localparam int CH_W  = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
    localparam int PRE_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam int MS_W  = (PERIOD_MS > 1) ? $clog2(PERIOD_MS) : 1;

    localparam logic [IDX_W-1:0] CLOSE_IDX = IDX_W'(CLOSE_POS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_POS);
`ifdef MOTOR_PKT_CHECKSUM_EN
    localparam logic [IDX_W-1:0] STAR_IDX  = IDX_W'(CLOSE_POS + 1);
    localparam logic [IDX_W-1:0] CKHI_IDX  = IDX_W'(CLOSE_POS + 2);
    localparam logic [IDX_W-1:0] CKLO_IDX  = IDX_W'(CLOSE_POS + 3);
`endif
    localparam logic [3:0] OFF_COMMA = 4'(5 + H);
    localparam logic [3:0] OFF_HEX0  = 4'd5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [PRE_W-1:0]            presc_reg;
    logic [MS_W-1:0]             ms_reg;
    logic [0:0]                  state_reg;
    logic                        pending_reg;
    logic [NUM_MOTORS*CMD_W-1:0] last_sent_reg;
    logic [IDX_W-1:0]            idx_reg;
    logic [CH_W-1:0]             ch_reg;
    logic [3:0]                  off_reg;
    logic [NUM_MOTORS*HW-1:0]    snap_flat;
    logic [HW-1:0]               snap_cur;
    logic [HW-1:0]               snap_shift;
    logic [3:0]                  dig;
    logic [7:0]                  cur_byte;
    logic                        strobe, idle, trig, start, accept, last_byte;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign strobe    = enable && (presc_reg == PRE_W'(CLKS_PER_MS - 1))
                              && (ms_reg == MS_W'(PERIOD_MS - 1));
    assign idle      = (state_reg == ST_IDLE);
    // On-change triggers only fire from an idle, non-pending packetizer, so
    // they never collide with a frame in flight.
    assign trig      = enable && (mode_on_change
                                  ? (idle && !pending_reg && (motor_cmd != last_sent_reg))
                                  : strobe);
    assign start     = idle && (trig || pending_reg);
    assign accept    = uart_valid && uart_ready;
    assign last_byte = (idx_reg == LAST_IDX);

    assign uart_valid = (state_reg == ST_SEND);
    assign busy       = (state_reg == ST_SEND);
    assign uart_data  = uart_valid ? cur_byte : 8'h00;
    assign frame_done = !rst && accept && last_byte;
    // A trigger while sending with one already queued has nowhere to go.
    assign overrun    = !rst && trig && pending_reg && !idle;

    // ms prescaler and period counter; both held at zero while disabled
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            presc_reg <= '0;
            ms_reg    <= '0;
        end else if (presc_reg == PRE_W'(CLKS_PER_MS - 1)) begin
            presc_reg <= '0;
            if (ms_reg == MS_W'(PERIOD_MS - 1))
                ms_reg <= '0;
            else
                ms_reg <= ms_reg + 1'b1;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    // one-deep trigger queue; a trigger coinciding with a start stays queued
    always_ff @(posedge clk) begin
        if (rst)
            pending_reg <= 1'b0;
        else if (start)
            pending_reg <= pending_reg && trig;
        else if (trig)
            pending_reg <= 1'b1;
    end

    // frame sequencer: byte index plus channel/offset counters for the body
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            ch_reg        <= '0;
            off_reg       <= '0;
            last_sent_reg <= '0;
        end else if (start) begin
            state_reg     <= ST_SEND;
            idx_reg       <= '0;
            ch_reg        <= '0;
            off_reg       <= '0;
            last_sent_reg <= motor_cmd;
        end else if (accept) begin
            if (last_byte)
                state_reg <= ST_IDLE;
            idx_reg <= idx_reg + 1'b1;
            if ((idx_reg != '0) && (idx_reg < CLOSE_IDX)) begin
                if (off_reg == OFF_COMMA) begin
                    off_reg <= '0;
                    ch_reg  <= ch_reg + 1'b1;
                end else begin
                    off_reg <= off_reg + 1'b1;
                end
            end
        end
    end

    // per-channel snapshot, zero-padded to whole nibbles
    generate
        for (genvar gi = 0; gi < NUM_MOTORS; gi++) begin : g_snap
            logic [HW-1:0] snap_ch_reg;
            // capture at frame start; the live input is never read mid-frame
            always_ff @(posedge clk) begin
                if (rst)
                    snap_ch_reg <= '0;
                else if (start)
                    snap_ch_reg <= HW'(motor_cmd[gi*CMD_W +: CMD_W]);
            end
            assign snap_flat[gi*HW +: HW] = snap_ch_reg;
        end
    endgenerate

`ifdef MOTOR_PKT_CHECKSUM_EN
    logic [7:0] ck_reg;
    // running XOR of every accepted byte from '{' through '}'
    always_ff @(posedge clk) begin
        if (rst)
            ck_reg <= '0;
        else if (start)
            ck_reg <= '0;
        else if (accept && (idx_reg <= CLOSE_IDX))
            ck_reg <= ck_reg ^ cur_byte;
    end
`endif

    assign snap_cur   = snap_flat[int'(ch_reg)*HW +: HW];
    assign dig        = off_reg - OFF_HEX0;
    assign snap_shift = snap_cur << {dig, 2'b00};

    // current frame byte as a function of position and snapshot
    always_comb begin
        cur_byte = 8'h0A;
        if (idx_reg == '0) begin
            cur_byte = 8'h7B;
        end else if (idx_reg < CLOSE_IDX) begin
            case (off_reg)
                4'd0:    cur_byte = 8'h22;
                4'd1:    cur_byte = 8'h6D;
                4'd2:    cur_byte = 8'h30 + 8'(ch_reg);
                4'd3:    cur_byte = 8'h22;
                4'd4:    cur_byte = 8'h3A;
                default: cur_byte = (off_reg == OFF_COMMA) ? 8'h2C
                                                           : hex_char(snap_shift[HW-1 -: 4]);
            endcase
        end else if (idx_reg == CLOSE_IDX) begin
            cur_byte = 8'h7D;
`ifdef MOTOR_PKT_CHECKSUM_EN
        end else if (idx_reg == STAR_IDX) begin
            cur_byte = 8'h2A;
        end else if (idx_reg == CKHI_IDX) begin
            cur_byte = hex_char(ck_reg[7:4]);
        end else if (idx_reg == CKLO_IDX) begin
            cur_byte = hex_char(ck_reg[3:0]);
`endif
        end
    end

endmodule

// File: tb/tb_motor_cmd_packetizer.sv
// tb_motor_cmd_packetizer
// Randomised and directed checks of motor_cmd_packetizer against a string-based
// frame model. Define MOTOR_PKT_CHECKSUM_EN for both bench and RTL together.
module tb_motor_cmd_packetizer;
    localparam int NM  = 2;
    localparam int CW  = 5;
    localparam int CPM = 10;
    localparam int PMS = 3;
    localparam int H   = (CW + 3) / 4;
`ifdef MOTOR_PKT_CHECKSUM_EN
    localparam int FLEN = 3 + NM*(5+H) + (NM-1) + 3;
`else
    localparam int FLEN = 3 + NM*(5+H) + (NM-1);
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b1;
    logic          mode_on_change = 1'b0;
    logic          uart_ready = 1'b1;
    logic [NM*CW-1:0] motor_cmd = '0;
    logic [7:0]    uart_data;
    logic          uart_valid, busy, frame_done, overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int ready_mode = 0;       // 0 = held by main, 1 = random, 2 = toggle
    int cyc = 0;
    int first_valid_cyc = -1;
    int done_cnt = 0;
    int ovr_cnt = 0;
    int in_frame = 0;
    byte unsigned rx_q[$];
    int start_q[$];
    int done_q[$];
    logic       hold_pend = 1'b0;
    logic [7:0] hold_data = 8'h00;

    always #5 clk = ~clk;

    motor_cmd_packetizer #(
        .NUM_MOTORS(NM), .CMD_W(CW), .CLKS_PER_MS(CPM), .PERIOD_MS(PMS)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode_on_change(mode_on_change),
        .motor_cmd(motor_cmd), .uart_data(uart_data), .uart_valid(uart_valid),
        .uart_ready(uart_ready), .busy(busy), .frame_done(frame_done),
        .overrun(overrun)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hex_ch(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(55 + n);
    endfunction

    // Expected frame text built directly from the command values.
    function automatic string model_frame(input logic [NM*CW-1:0] cmd);
        string s;
        int v;
        int ck;
        s = "{";
        for (int i = 0; i < NM; i++) begin
            v = int'(cmd[i*CW +: CW]);
            s = {s, $sformatf("\"m%0d\":", i)};
            for (int d = H-1; d >= 0; d--)
                s = {s, $sformatf("%c", hex_ch((v >> (4*d)) & 15))};
            if (i < NM-1) s = {s, ","};
        end
        s = {s, "}"};
`ifdef MOTOR_PKT_CHECKSUM_EN
        ck = 0;
        for (int k = 0; k < s.len(); k++) ck = ck ^ int'(s[k]);
        s = {s, $sformatf("*%c%c", hex_ch(ck >> 4), hex_ch(ck & 15))};
`else
        ck = 0;
`endif
        s = {s, "\n"};
        return s;
    endfunction

    // Byte-stream monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            cyc = 0;
            hold_pend = 1'b0;
            in_frame = 0;
        end else begin
            cyc++;
            if (hold_pend) begin
                check_eq("hold_valid", 64'(uart_valid), 64'd1);
                check_eq("hold_data", 64'(uart_data), 64'(hold_data));
            end
            hold_pend = uart_valid && !uart_ready;
            hold_data = uart_data;
            if (uart_valid) check_eq("busy_in_frame", 64'(busy), 64'd1);
            if (uart_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (uart_valid && uart_ready) begin
                if (in_frame == 0) start_q.push_back(cyc);
                in_frame++;
                rx_q.push_back(uart_data);
                if (uart_data == 8'h0A) begin
                    in_frame = 0;
                    done_q.push_back(cyc);
                end
            end
            if (frame_done) begin
                done_cnt++;
                check_eq("done_on_nl", 64'({uart_valid & uart_ready, uart_data}), 64'h10A);
            end
            if (overrun) ovr_cnt++;
        end
    end

    // uart_ready pattern generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) uart_ready = 1'($urandom_range(0, 1));
            else if (ready_mode == 2) uart_ready = ~uart_ready;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick(3);
        rx_q.delete();
        start_q.delete();
        done_q.delete();
        first_valid_cyc = -1;
        done_cnt = 0;
        ovr_cnt = 0;
        rst = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int t;
        t = 0;
        while (rx_q.size() < n && t < budget) begin
            tick(1);
            t++;
        end
        if (rx_q.size() < n) check_eq({tag, "_timeout"}, 64'(rx_q.size()), 64'(n));
    endtask

    task automatic check_frame(input logic [NM*CW-1:0] cmd, input string tag);
        string s;
        byte unsigned got;
        s = model_frame(cmd);
        if (rx_q.size() < s.len()) begin
            check_eq({tag, "_avail"}, 64'(rx_q.size()), 64'(s.len()));
            return;
        end
        for (int k = 0; k < s.len(); k++) begin
            got = rx_q.pop_front();
            check_eq($sformatf("%s_b%0d", tag, k+1), 64'(got), 64'(s[k]));
        end
        $display("frame %s cmd=%h len=%0d checked", tag, cmd, s.len());
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    initial begin
        logic [NM*CW-1:0] nc;

        // reset state
        rst = 1'b1;
        tick(3);
        @(negedge clk);
        check_eq("rst_valid", 64'(uart_valid), 64'd0);
        check_eq("rst_data", 64'(uart_data), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(frame_done), 64'd0);
        check_eq("rst_overrun", 64'(overrun), 64'd0);
        @(posedge clk);
        #1;

        // periodic timing, ready always high
        mode_on_change = 1'b0;
        motor_cmd = {5'h1F, 5'h05};
        apply_reset();
        wait_bytes(2*FLEN, 150, "per");
        check_eq("per_first_valid_cyc", 64'(first_valid_cyc), 64'd31);
        check_eq("per_start0", 64'(q_at(start_q, 0)), 64'd31);
        check_eq("per_start1", 64'(q_at(start_q, 1)), 64'd61);
        check_frame({5'h1F, 5'h05}, "per_f1");
        check_frame({5'h1F, 5'h05}, "per_f2");
        check_eq("per_done_cnt", 64'(done_cnt), 64'd2);
        check_eq("per_ovr_cnt", 64'(ovr_cnt), 64'd0);
        enable = 1'b0;
        tick(40);
        check_eq("per_disabled_quiet", 64'(rx_q.size()), 64'd0);

        // on-change mode, random commands under random / toggling backpressure
        enable = 1'b1;
        mode_on_change = 1'b1;
        motor_cmd = '0;
        apply_reset();
        for (int it = 0; it < 8; it++) begin
            ready_mode = (it == 3) ? 2 : 1;
            do nc = (NM*CW)'($urandom); while (nc == motor_cmd);
            motor_cmd = nc;
            wait_bytes(FLEN, 400, "rnd");
            check_frame(nc, $sformatf("rnd%0d", it));
            tick(12);
            check_eq("rnd_quiet", 64'(rx_q.size()), 64'd0);
        end
        ready_mode = 0;
        uart_ready = 1'b1;

        // on-change with the input moving mid-frame
        motor_cmd = '0;
        apply_reset();
        motor_cmd = {5'h1F, 5'h05};
        wait_bytes(5, 50, "chg_mid");
        motor_cmd[CW +: CW] = 5'h00;
        wait_bytes(2*FLEN, 100, "chg");
        check_frame({5'h1F, 5'h05}, "chg_f1");
        check_frame({5'h00, 5'h05}, "chg_f2");
        tick(60);
        check_eq("chg_no_third", 64'(rx_q.size()), 64'd0);

        // periodic with the sink stalled across two further strobes
        mode_on_change = 1'b0;
        uart_ready = 1'b0;
        motor_cmd = {5'h1F, 5'h05};
        apply_reset();
        tick(95);
        check_eq("ovr_count", 64'(ovr_cnt), 64'd1);
        check_eq("ovr_nothing_sent", 64'(rx_q.size()), 64'd0);
        check_eq("ovr_busy", 64'(busy), 64'd1);
        enable = 1'b0;
        uart_ready = 1'b1;
        wait_bytes(2*FLEN, 100, "ovr");
        check_frame({5'h1F, 5'h05}, "ovr_f1");
        check_frame({5'h1F, 5'h05}, "ovr_f2");
        check_eq("ovr_back_to_back", 64'(q_at(start_q, 1) - q_at(done_q, 0)), 64'd2);
        tick(40);
        check_eq("ovr_exactly_two", 64'(done_cnt), 64'd2);
        check_eq("ovr_no_more", 64'(rx_q.size()), 64'd0);
        check_eq("ovr_count_final", 64'(ovr_cnt), 64'd1);

        // reset while byte 7 is on the bus
        enable = 1'b1;
        apply_reset();
        wait_bytes(6, 60, "mrst");
        rst = 1'b1;
        tick(1);
        check_eq("mrst_valid", 64'(uart_valid), 64'd0);
        check_eq("mrst_busy", 64'(busy), 64'd0);
        check_eq("mrst_data", 64'(uart_data), 64'd0);
        apply_reset();
        wait_bytes(FLEN, 60, "mrst_re");
        check_eq("mrst_first_valid_cyc", 64'(first_valid_cyc), 64'd31);
        check_frame({5'h1F, 5'h05}, "mrst_f");
        enable = 1'b0;
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // hard stop if the sequence above ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
